// File: rtl/picomips_pkg.sv
// Shared types and instruction field positions for the picoMIPS fetch/decode path.
package picomips_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_ADDI  = 4'd2,
        OP_SUB   = 4'd3,
        OP_MULI  = 4'd4,
        OP_BEQ   = 4'd5,
        OP_BNE   = 4'd6,
        OP_WAITH = 4'd7,
        OP_WAITL = 4'd8,
        OP_HALT  = 4'd9
    } op_t;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_MUL = 3'd3
    } alu_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 6;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle between the fetch controller (master) and the PC/datapath (slave).
interface fetch_ctrl_if #(
    parameter int p_size = 6,
    parameter int i_size = 16
);
    logic [i_size-1:0] instr;
    logic              z_flag;
    logic              hs_in;
    logic              pc_incr;
    logic              pc_relbranch;
    logic [p_size-1:0] branch_addr;
    logic              reg_we;
    logic [2:0]        alu_func;
    logic              imm_sel;
    logic [5:0]        imm;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic              halted;

    modport master (
        input  instr, z_flag, hs_in,
        output pc_incr, pc_relbranch, branch_addr, reg_we, alu_func,
               imm_sel, imm, rd, rs, halted
    );

    modport slave (
        output instr, z_flag, hs_in,
        input  pc_incr, pc_relbranch, branch_addr, reg_we, alu_func,
               imm_sel, imm, rd, rs, halted
    );
endinterface

// File: rtl/instr_decode.sv
// Combinational opcode decode into ALU controls and instruction class flags.
module instr_decode
    import picomips_pkg::*;
(
    input  logic [3:0] op_i,
    output alu_t       alu_func_o,
    output logic       imm_sel_o,
    output logic       is_alu_o,
    output logic       is_branch_o,
    output logic       is_wait_o,
    output logic       is_halt_o
);

    always_comb begin
        alu_func_o  = ALU_NOP;
        imm_sel_o   = 1'b0;
        is_alu_o    = 1'b0;
        is_branch_o = 1'b0;
        is_wait_o   = 1'b0;
        is_halt_o   = 1'b0;
        // Opcodes 10-15 fall through to the defaults and execute as NOP.
        case (op_i)
            OP_ADD:   begin alu_func_o = ALU_ADD; is_alu_o = 1'b1; end
            OP_ADDI:  begin alu_func_o = ALU_ADD; is_alu_o = 1'b1; imm_sel_o = 1'b1; end
            OP_SUB:   begin alu_func_o = ALU_SUB; is_alu_o = 1'b1; end
            OP_MULI:  begin alu_func_o = ALU_MUL; is_alu_o = 1'b1; imm_sel_o = 1'b1; end
            OP_BEQ,
            OP_BNE:   is_branch_o = 1'b1;
            OP_WAITH,
            OP_WAITL: is_wait_o = 1'b1;
            OP_HALT:  is_halt_o = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// picoMIPS fetch/decode controller: latches program memory output and drives
// PC strobes plus datapath controls through a FETCH/EXEC sequence.
//
// state    | meaning
// ST_FETCH | load ir from program memory, all strobes low
// ST_EXEC  | execute ir: write-back, PC increment or relative branch
// ST_WAIT  | stall until hs_in reaches the level WAITH/WAITL asks for
// ST_HALT  | core stopped, left only by reset
module fetch_ctrl
    import picomips_pkg::*;
#(
    parameter int p_size = 6,
    parameter int i_size = 16
) (
    input  logic          clk,
    input  logic          n_reset,
    fetch_ctrl_if.master  bus
);

    state_t            state_q, state_d;
    logic [i_size-1:0] ir_q, ir_d;

    alu_t       alu_func_w;
    logic       imm_sel_w;
    logic       is_alu_w;
    logic       is_branch_w;
    logic       is_wait_w;
    logic       is_halt_w;
    logic [3:0] op_w;
    logic       br_take_w;
    logic       hs_match_w;
    logic       pc_incr_w;
    logic       pc_relbranch_w;
    logic       reg_we_w;

    assign op_w = ir_q[OP_MSB:OP_LSB];

    instr_decode u_decode (
        .op_i        (op_w),
        .alu_func_o  (alu_func_w),
        .imm_sel_o   (imm_sel_w),
        .is_alu_o    (is_alu_w),
        .is_branch_o (is_branch_w),
        .is_wait_o   (is_wait_w),
        .is_halt_o   (is_halt_w)
    );

    assign br_take_w  = (op_w == OP_BEQ) ? bus.z_flag : ~bus.z_flag;
    assign hs_match_w = (op_w == OP_WAITH) ? bus.hs_in : ~bus.hs_in;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ir_d           = ir_q;
        pc_incr_w      = 1'b0;
        pc_relbranch_w = 1'b0;
        reg_we_w       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_d    = bus.instr;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_halt_w) begin
                    state_d = ST_HALT;
                end else if (is_branch_w) begin
                    pc_relbranch_w = br_take_w;
                    pc_incr_w      = ~br_take_w;
                    state_d        = ST_FETCH;
                end else if (is_wait_w) begin
                    pc_incr_w = hs_match_w;
                    state_d   = hs_match_w ? ST_FETCH : ST_WAIT;
                end else begin
                    reg_we_w  = is_alu_w;
                    pc_incr_w = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (hs_match_w) begin
                    pc_incr_w = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Sign-preserving resize of the 6-bit immediate into the PC offset width.
    assign bus.branch_addr  = p_size'($signed(ir_q[IMM_MSB:IMM_LSB]));
    assign bus.pc_incr      = pc_incr_w;
    assign bus.pc_relbranch = pc_relbranch_w;
    assign bus.reg_we       = reg_we_w;
    assign bus.alu_func     = alu_func_w;
    assign bus.imm_sel      = imm_sel_w;
    assign bus.imm          = ir_q[IMM_MSB:IMM_LSB];
    assign bus.rd           = ir_q[RD_MSB:RD_LSB];
    assign bus.rs           = ir_q[RS_MSB:RS_LSB];
    assign bus.halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: table of single-instruction vectors plus
// hand-written wait, halt and reset sequences.
module tb_fetch_ctrl;
    import picomips_pkg::*;

    logic clk;
    logic n_reset;
    int   total;
    int   passed;

    fetch_ctrl_if #(.p_size(6), .i_size(16)) bus ();

    fetch_ctrl #(.p_size(6), .i_size(16)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        z;
        logic        hs;
        logic [25:0] exp_exec;
    } vec_t;

    localparam logic [25:0] SMASK = 26'h3800000;

    vec_t vecs[14];

    function automatic logic [25:0] mk(input logic inc, input logic rel, input logic we,
                                       input logic [2:0] alu, input logic isel,
                                       input logic [5:0] imm, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [5:0] ba,
                                       input logic hlt);
        return {inc, rel, we, alu, isel, imm, rd, rs, ba, hlt};
    endfunction

    function automatic logic [25:0] outs();
        return {bus.pc_incr, bus.pc_relbranch, bus.reg_we, bus.alu_func, bus.imm_sel,
                bus.imm, bus.rd, bus.rs, bus.branch_addr, bus.halted};
    endfunction

    task automatic chk(input string nm, input logic [25:0] act, input logic [25:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        passed = 0;

        vecs[0]  = '{16'h2205, 1'b0, 1'b0, mk(1,0,1,ALU_ADD,1,6'h05,3'd1,3'd0,6'h05,0)};
        vecs[1]  = '{16'h14C0, 1'b0, 1'b0, mk(1,0,1,ALU_ADD,0,6'h00,3'd2,3'd3,6'h00,0)};
        vecs[2]  = '{16'h3940, 1'b0, 1'b0, mk(1,0,1,ALU_SUB,0,6'h00,3'd4,3'd5,6'h00,0)};
        vecs[3]  = '{16'h4C21, 1'b0, 1'b0, mk(1,0,1,ALU_MUL,1,6'h21,3'd6,3'd0,6'h21,0)};
        vecs[4]  = '{16'h503E, 1'b1, 1'b0, mk(0,1,0,ALU_NOP,0,6'h3E,3'd0,3'd0,6'h3E,0)};
        vecs[5]  = '{16'h503E, 1'b0, 1'b0, mk(1,0,0,ALU_NOP,0,6'h3E,3'd0,3'd0,6'h3E,0)};
        vecs[6]  = '{16'h603E, 1'b0, 1'b0, mk(0,1,0,ALU_NOP,0,6'h3E,3'd0,3'd0,6'h3E,0)};
        vecs[7]  = '{16'h603E, 1'b1, 1'b0, mk(1,0,0,ALU_NOP,0,6'h3E,3'd0,3'd0,6'h3E,0)};
        vecs[8]  = '{16'h5000, 1'b1, 1'b0, mk(0,1,0,ALU_NOP,0,6'h00,3'd0,3'd0,6'h00,0)};
        vecs[9]  = '{16'h0000, 1'b0, 1'b0, mk(1,0,0,ALU_NOP,0,6'h00,3'd0,3'd0,6'h00,0)};
        vecs[10] = '{16'hF123, 1'b0, 1'b0, mk(1,0,0,ALU_NOP,0,6'h23,3'd0,3'd4,6'h23,0)};
        vecs[11] = '{16'h8000, 1'b0, 1'b0, mk(1,0,0,ALU_NOP,0,6'h00,3'd0,3'd0,6'h00,0)};
        vecs[12] = '{16'h7000, 1'b0, 1'b1, mk(1,0,0,ALU_NOP,0,6'h00,3'd0,3'd0,6'h00,0)};
        vecs[13] = '{16'hD5C7, 1'b0, 1'b0, mk(1,0,0,ALU_NOP,0,6'h07,3'd2,3'd7,6'h07,0)};

        n_reset    = 1'b0;
        bus.instr  = 16'h0000;
        bus.z_flag = 1'b0;
        bus.hs_in  = 1'b0;
        #3;
        chk("reset_state", outs(), 26'd0);
        step();
        step();
        n_reset = 1'b1;

        // Each vector: FETCH (strobes low), EXEC (full compare), back to FETCH.
        for (int i = 0; i < 14; i++) begin
            bus.instr  = vecs[i].instr;
            bus.z_flag = vecs[i].z;
            bus.hs_in  = vecs[i].hs;
            #1;
            chk($sformatf("fetch_vec%0d", i), outs() & SMASK, 26'd0);
            step();
            chk($sformatf("exec_vec%0d", i), outs(), vecs[i].exp_exec);
            step();
        end

        // WAITH held off by hs_in low for five cycles.
        bus.instr = 16'h7000;
        bus.hs_in = 1'b0;
        #1;
        chk("waith_fetch", outs() & SMASK, 26'd0);
        step();
        chk("waith_exec", outs(), 26'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("waith_wait%0d", i), outs(), 26'd0);
        end
        bus.hs_in = 1'b1;
        #1;
        chk("waith_release", outs(), mk(1,0,0,ALU_NOP,0,0,0,0,0,0));
        step();
        chk("waith_back_fetch", outs() & SMASK, 26'd0);

        // HALT, then recovery by reset.
        bus.instr = 16'h9000;
        step();
        chk("halt_exec", outs(), 26'd0);
        bus.instr = 16'h14C0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("halted%0d", i), outs(), mk(0,0,0,ALU_NOP,0,0,0,0,0,1));
        end
        #2;
        n_reset = 1'b0;
        #1;
        chk("halt_reset_async", outs(), 26'd0);
        n_reset = 1'b1;
        bus.instr = 16'h2205;
        #1;
        chk("halt_reset_fetch", outs(), 26'd0);
        step();
        chk("after_halt_exec", outs(), vecs[0].exp_exec);
        step();

        // Reset asserted in the middle of EXEC of ADD.
        bus.instr = 16'h14C0;
        step();
        chk("add_exec", outs(), vecs[1].exp_exec);
        #1;
        n_reset = 1'b0;
        #1;
        chk("mid_exec_reset", outs(), 26'd0);
        #1;
        n_reset = 1'b1;
        bus.instr = 16'h2205;
        #1;
        chk("post_reset_fetch", outs(), 26'd0);
        step();
        chk("post_reset_exec", outs(), vecs[0].exp_exec);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
